// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, funct/ALUOp constants and mult/div FSM states
package alu_pkg;
   localparam logic [3:0] CTRL_AND  = 4'b0000;
   localparam logic [3:0] CTRL_OR   = 4'b0001;
   localparam logic [3:0] CTRL_ADD  = 4'b0010;
   localparam logic [3:0] CTRL_XOR  = 4'b0011;
   localparam logic [3:0] CTRL_SUB  = 4'b0110;
   localparam logic [3:0] CTRL_SLT  = 4'b0111;
   localparam logic [3:0] CTRL_SLTU = 4'b1011;
   localparam logic [3:0] CTRL_NOR  = 4'b1100;
   localparam logic [3:0] CTRL_SLL  = 4'b1000;
   localparam logic [3:0] CTRL_SRL  = 4'b1001;
   localparam logic [3:0] CTRL_SRA  = 4'b1010;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SUBU  = 6'b100011;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;
   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_SRA   = 6'b000011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [1:0] AOP_ADD   = 2'b00;
   localparam logic [1:0] AOP_SUB   = 2'b01;
   localparam logic [1:0] AOP_RTYPE = 2'b10;
   localparam logic [1:0] AOP_OR    = 2'b11;
   typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_e;
endpackage

// File: rtl/ex_alu_muldiv_if.sv
// ex_alu_muldiv_if: EX-stage op/result bundle; ovf_o exists only with ALU_OVF_DETECT_EN
interface ex_alu_muldiv_if #(parameter int WIDTH = 32, parameter int SHAMT_W = 5);
   logic               valid_i;
   logic               flush_i;
   logic [1:0]         alu_op_i;
   logic [5:0]         funct_i;
   logic [SHAMT_W-1:0] shamt_i;
   logic [WIDTH-1:0]   src_a_i;
   logic [WIDTH-1:0]   src_b_i;
   logic [WIDTH-1:0]   result_o;
   logic               result_vld_o;
   logic               zero_o;
   logic               stall_o;
   logic               div_zero_o;
`ifdef ALU_OVF_DETECT_EN
   logic               ovf_o;
`endif
   modport master (
`ifdef ALU_OVF_DETECT_EN
      input ovf_o,
`endif
      output valid_i, flush_i, alu_op_i, funct_i, shamt_i, src_a_i, src_b_i,
      input result_o, result_vld_o, zero_o, stall_o, div_zero_o
   );
   modport slave (
`ifdef ALU_OVF_DETECT_EN
      output ovf_o,
`endif
      input valid_i, flush_i, alu_op_i, funct_i, shamt_i, src_a_i, src_b_i,
      output result_o, result_vld_o, zero_o, stall_o, div_zero_o
   );
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: 1 bit/cycle shift-add multiply and restoring divide into HI/LO
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CW    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);
   md_state_e state, state_n;
   logic [CW-1:0] cnt;
   logic [2*WIDTH-1:0] x, acc, acc_n, prod, x_div;
   logic [WIDTH-1:0] y, mag_a, mag_b, q_f, r_f;
   logic [WIDTH:0] top, diff;
   logic neg_q, neg_r, dz, last, ge;
   assign busy = state != IDLE;
   assign dz = is_div && b == '0;
   assign last = cnt == CW'(WIDTH - 1);
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   end
   // next state: flush aborts, divide-by-zero never leaves IDLE
   always_comb begin
      state_n = state;
      state_n = flush ? IDLE :
                state == IDLE ? ((start && !dz) ? (is_div ? DIV : MUL) : IDLE) :
                last ? IDLE : state;
   end
   // one multiply step, one restoring-divide step and final sign fix-ups
   always_comb begin
      mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
      mag_b = (is_signed && b[WIDTH-1]) ? -b : b;
      acc_n = acc + (y[0] ? x : '0);
      prod  = neg_q ? -acc_n : acc_n;
      top   = {x[2*WIDTH-1:WIDTH], x[WIDTH-1]};
      diff  = top - {1'b0, y};
      ge    = !diff[WIDTH];
      x_div = {ge ? diff[WIDTH-1:0] : top[WIDTH-1:0], x[WIDTH-2:0], ge};
      q_f   = neg_q ? -x_div[WIDTH-1:0] : x_div[WIDTH-1:0];
      r_f   = neg_r ? -x_div[2*WIDTH-1:WIDTH] : x_div[2*WIDTH-1:WIDTH];
   end
   // operand/partial registers and HI/LO; HI/LO change only on completion or divide-by-zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
         acc <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         cnt <= '0;
         hi <= '0;
         lo <= '0;
         div_zero <= 1'b0;
      end else begin
         div_zero <= start && dz && !flush;
         if (flush) cnt <= '0;
         else if (state == IDLE) begin
            cnt <= '0;
            if (start && dz) begin
               hi <= a;
               lo <= '1;
            end else if (start) begin
               x <= {{WIDTH{1'b0}}, mag_a};
               y <= mag_b;
               acc <= '0;
               neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
               neg_r <= is_signed && a[WIDTH-1];
            end
         end else begin
            cnt <= cnt + 1'b1;
            if (state == MUL) begin
               acc <= acc_n;
               x <= x << 1;
               y <= y >> 1;
               if (last) {hi, lo} <= prod;
            end else begin
               x <= x_div;
               if (last) begin
                  hi <= r_f;
                  lo <= q_f;
               end
            end
         end
      end
   end
endmodule

// File: rtl/ex_alu_muldiv.sv
// ex_alu_muldiv: EX-stage decode, ALU with registered result, HI/LO mult/div and stall (optional ALU_OVF_DETECT_EN)
module ex_alu_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input logic clk,
   input logic rst_n,
   ex_alu_muldiv_if.slave bus
);
   logic [3:0] ctrl;
   logic is_mfhi, is_mflo, is_md, accept, busy;
   logic [WIDTH-1:0] a, b, alu_y, y, hi, lo;
   assign a = bus.src_a_i;
   assign b = bus.src_b_i;
   assign bus.stall_o = bus.valid_i && busy && (is_mfhi || is_mflo || is_md);
   assign accept = bus.valid_i && !bus.stall_o && !bus.flush_i;
   // ALUOp/funct decode
   always_comb begin
      ctrl = CTRL_AND;
      is_mfhi = 1'b0;
      is_mflo = 1'b0;
      is_md = 1'b0;
      case (bus.alu_op_i)
         AOP_ADD: ctrl = CTRL_ADD;
         AOP_SUB: ctrl = CTRL_SUB;
         AOP_OR:  ctrl = CTRL_OR;
         default:
            case (bus.funct_i)
               F_ADD, F_ADDU: ctrl = CTRL_ADD;
               F_SUB, F_SUBU: ctrl = CTRL_SUB;
               F_OR:   ctrl = CTRL_OR;
               F_XOR:  ctrl = CTRL_XOR;
               F_NOR:  ctrl = CTRL_NOR;
               F_SLT:  ctrl = CTRL_SLT;
               F_SLTU: ctrl = CTRL_SLTU;
               F_SLL:  ctrl = CTRL_SLL;
               F_SRL:  ctrl = CTRL_SRL;
               F_SRA:  ctrl = CTRL_SRA;
               F_MFHI: is_mfhi = 1'b1;
               F_MFLO: is_mflo = 1'b1;
               F_MULT, F_MULTU, F_DIV, F_DIVU: is_md = 1'b1;
               default: ctrl = CTRL_AND;
            endcase
      endcase
   end
   // single-cycle ALU; mfhi/mflo read HI/LO directly
   always_comb begin
      case (ctrl)
         CTRL_OR:   alu_y = a | b;
         CTRL_ADD:  alu_y = a + b;
         CTRL_XOR:  alu_y = a ^ b;
         CTRL_SUB:  alu_y = a - b;
         CTRL_SLT:  alu_y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         CTRL_SLTU: alu_y = {{(WIDTH-1){1'b0}}, a < b};
         CTRL_NOR:  alu_y = ~(a | b);
         CTRL_SLL:  alu_y = b << bus.shamt_i;
         CTRL_SRL:  alu_y = b >> bus.shamt_i;
         CTRL_SRA:  alu_y = $signed(b) >>> bus.shamt_i;
         default:   alu_y = a & b;
      endcase
      y = is_mfhi ? hi : is_mflo ? lo : alu_y;
   end
   // result register; mult/div issue produces no result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.result_o <= '0;
         bus.result_vld_o <= 1'b0;
         bus.zero_o <= 1'b0;
      end else begin
         bus.result_vld_o <= accept && !is_md;
         if (accept && !is_md) begin
            bus.result_o <= y;
            bus.zero_o <= y == '0;
         end
      end
   end
`ifdef ALU_OVF_DETECT_EN
   logic ovf_chk, ovf_n;
   // signed overflow for add/sub variants that trap; addu/subu excluded
   always_comb begin
      ovf_chk = bus.alu_op_i == AOP_ADD || bus.alu_op_i == AOP_SUB ||
                (bus.alu_op_i == AOP_RTYPE && (bus.funct_i == F_ADD || bus.funct_i == F_SUB));
      ovf_n = ctrl == CTRL_ADD ? (a[WIDTH-1] == b[WIDTH-1]) && (alu_y[WIDTH-1] != a[WIDTH-1]) :
              ctrl == CTRL_SUB ? (a[WIDTH-1] != b[WIDTH-1]) && (alu_y[WIDTH-1] != a[WIDTH-1]) : 1'b0;
   end
   // overflow flag registered alongside the result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.ovf_o <= 1'b0;
      else if (accept && !is_md) bus.ovf_o <= ovf_chk && ovf_n;
   end
`endif
   muldiv_iter #(.WIDTH(WIDTH), .CW(SHAMT_W)) u_md (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (accept && is_md),
      .is_div    (bus.funct_i[1]),
      .is_signed (!bus.funct_i[0]),
      .a         (a),
      .b         (b),
      .flush     (bus.flush_i),
      .busy      (busy),
      .hi        (hi),
      .lo        (lo),
      .div_zero  (bus.div_zero_o)
   );
endmodule

// File: tb/tb_ex_alu_muldiv.sv
// tb_ex_alu_muldiv: directed vector table plus mult/div, flush and reset sequences
module tb_ex_alu_muldiv;
   import alu_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;
   int st;
   ex_alu_muldiv_if bus ();
   ex_alu_muldiv dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic [1:0]  op;
      logic [5:0]  fn;
      logic [4:0]  sh;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
   } vec_t;
   vec_t v[16];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   // call at a negedge; returns at the negedge after the op was accepted
   task automatic do_op(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b, output int stalls);
      bus.valid_i = 1'b1;
      bus.alu_op_i = op;
      bus.funct_i = fn;
      bus.shamt_i = sh;
      bus.src_a_i = a;
      bus.src_b_i = b;
      stalls = 0;
      #1;
      while (bus.stall_o && stalls < 200) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      @(negedge clk);
      bus.valid_i = 1'b0;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask
   initial begin
      v[0]  = '{AOP_RTYPE, F_ADD,  5'd0, 32'd7,        32'd5,        32'd12,        1'b0};
      v[1]  = '{AOP_SUB,   F_ADD,  5'd0, 32'h1234,     32'h1234,     32'h0,         1'b1};
      v[2]  = '{AOP_RTYPE, F_SRA,  5'd4, 32'h0,        32'h80000000, 32'hF8000000,  1'b0};
      v[3]  = '{AOP_RTYPE, F_SUB,  5'd0, 32'd5,        32'd7,        32'hFFFFFFFE,  1'b0};
      v[4]  = '{AOP_RTYPE, F_AND,  5'd0, 32'hF0F0,     32'hFF00,     32'hF000,      1'b0};
      v[5]  = '{AOP_RTYPE, F_OR,   5'd0, 32'hF0F0,     32'h0F00,     32'hFFF0,      1'b0};
      v[6]  = '{AOP_RTYPE, F_XOR,  5'd0, 32'hFF00,     32'h0F0F,     32'hF00F,      1'b0};
      v[7]  = '{AOP_RTYPE, F_NOR,  5'd0, 32'h0,        32'h0,        32'hFFFFFFFF,  1'b0};
      v[8]  = '{AOP_RTYPE, F_SLT,  5'd0, 32'hFFFFFFFF, 32'd1,        32'd1,         1'b0};
      v[9]  = '{AOP_RTYPE, F_SLTU, 5'd0, 32'hFFFFFFFF, 32'd1,        32'd0,         1'b1};
      v[10] = '{AOP_RTYPE, F_SLL,  5'd8, 32'h0,        32'h12,       32'h1200,      1'b0};
      v[11] = '{AOP_RTYPE, F_SRL,  5'd4, 32'h0,        32'h80000000, 32'h08000000,  1'b0};
      v[12] = '{AOP_OR,    F_ADD,  5'd0, 32'h1000,     32'h00FF,     32'h10FF,      1'b0};
      v[13] = '{AOP_ADD,   F_SUB,  5'd0, 32'h100,      32'hFFFFFFFC, 32'hFC,        1'b0};
      v[14] = '{AOP_RTYPE, 6'h3F,  5'd0, 32'hF0,       32'h3C,       32'h30,        1'b0};
      v[15] = '{AOP_RTYPE, F_ADDU, 5'd0, 32'hFFFFFFFF, 32'd1,        32'h0,         1'b1};
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
      bus.alu_op_i = 2'b00;
      bus.funct_i = 6'd0;
      bus.shamt_i = 5'd0;
      bus.src_a_i = '0;
      bus.src_b_i = '0;
      idle(3);
      chk("reset_result", bus.result_o, 32'h0);
      chk("reset_vld", {31'd0, bus.result_vld_o}, 32'd0);
      chk("reset_zero", {31'd0, bus.zero_o}, 32'd0);
      chk("reset_divzero", {31'd0, bus.div_zero_o}, 32'd0);
      rst_n = 1'b1;
      idle(1);
      for (int i = 0; i < 16; i++) begin
         do_op(v[i].op, v[i].fn, v[i].sh, v[i].a, v[i].b, st);
         chk($sformatf("vec%0d_result", i), bus.result_o, v[i].res);
         chk($sformatf("vec%0d_zero", i), {31'd0, bus.zero_o}, {31'd0, v[i].zero});
         chk($sformatf("vec%0d_vld", i), {31'd0, bus.result_vld_o}, 32'd1);
      end
      idle(1);
      chk("vld_drops", {31'd0, bus.result_vld_o}, 32'd0);
      // mult -3*5 then back-to-back mflo/mfhi
      do_op(AOP_RTYPE, F_MULT, 5'd0, 32'hFFFFFFFD, 32'd5, st);
      chk("mult_no_vld", {31'd0, bus.result_vld_o}, 32'd0);
      do_op(AOP_RTYPE, F_MFLO, 5'd0, 32'h0, 32'h0, st);
      chk("mult_stall_cycles", st, 32'd32);
      chk("mult_lo", bus.result_o, 32'hFFFFFFF1);
      chk("mflo_vld", {31'd0, bus.result_vld_o}, 32'd1);
      do_op(AOP_RTYPE, F_MFHI, 5'd0, 32'h0, 32'h0, st);
      chk("mfhi_no_stall", st, 32'd0);
      chk("mult_hi", bus.result_o, 32'hFFFFFFFF);
      // divu 100/7 with an independent add overlapping the divide
      do_op(AOP_RTYPE, F_DIVU, 5'd0, 32'd100, 32'd7, st);
      do_op(AOP_RTYPE, F_ADDU, 5'd0, 32'd3, 32'd4, st);
      chk("overlap_add_no_stall", st, 32'd0);
      chk("overlap_add_result", bus.result_o, 32'd7);
      do_op(AOP_RTYPE, F_MFLO, 5'd0, 32'h0, 32'h0, st);
      chk("divu_stall_cycles", st, 32'd31);
      chk("divu_lo", bus.result_o, 32'd14);
      do_op(AOP_RTYPE, F_MFHI, 5'd0, 32'h0, 32'h0, st);
      chk("divu_hi", bus.result_o, 32'd2);
      // signed div -7/2
      do_op(AOP_RTYPE, F_DIV, 5'd0, 32'hFFFFFFF9, 32'd2, st);
      do_op(AOP_RTYPE, F_MFLO, 5'd0, 32'h0, 32'h0, st);
      chk("div_lo", bus.result_o, 32'hFFFFFFFD);
      do_op(AOP_RTYPE, F_MFHI, 5'd0, 32'h0, 32'h0, st);
      chk("div_hi", bus.result_o, 32'hFFFFFFFF);
      // divide by zero
      do_op(AOP_RTYPE, F_DIV, 5'd0, 32'd100, 32'd0, st);
      chk("divzero_pulse", {31'd0, bus.div_zero_o}, 32'd1);
      chk("divzero_no_vld", {31'd0, bus.result_vld_o}, 32'd0);
      do_op(AOP_RTYPE, F_MFLO, 5'd0, 32'h0, 32'h0, st);
      chk("divzero_pulse_end", {31'd0, bus.div_zero_o}, 32'd0);
      chk("divzero_idle", st, 32'd0);
      chk("divzero_lo", bus.result_o, 32'hFFFFFFFF);
      do_op(AOP_RTYPE, F_MFHI, 5'd0, 32'h0, 32'h0, st);
      chk("divzero_hi", bus.result_o, 32'd100);
      // flush at cycle 10 of a mult leaves HI/LO untouched
      do_op(AOP_RTYPE, F_MULTU, 5'd0, 32'd6, 32'd7, st);
      idle(9);
      bus.flush_i = 1'b1;
      @(negedge clk);
      bus.flush_i = 1'b0;
      chk("flush_vld", {31'd0, bus.result_vld_o}, 32'd0);
      do_op(AOP_RTYPE, F_MFLO, 5'd0, 32'h0, 32'h0, st);
      chk("flush_idle", st, 32'd0);
      chk("flush_lo_kept", bus.result_o, 32'hFFFFFFFF);
      do_op(AOP_RTYPE, F_MFHI, 5'd0, 32'h0, 32'h0, st);
      chk("flush_hi_kept", bus.result_o, 32'd100);
      // flush kills a valid op in the same cycle
      bus.flush_i = 1'b1;
      do_op(AOP_RTYPE, F_ADD, 5'd0, 32'd1, 32'd1, st);
      bus.flush_i = 1'b0;
      chk("flush_op_killed", {31'd0, bus.result_vld_o}, 32'd0);
      chk("flush_op_result_kept", bus.result_o, 32'd100);
      // asynchronous reset in the middle of a divide
      do_op(AOP_RTYPE, F_DIVU, 5'd0, 32'd50, 32'd3, st);
      idle(5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_result", bus.result_o, 32'h0);
      chk("rst_vld", {31'd0, bus.result_vld_o}, 32'd0);
      chk("rst_divzero", {31'd0, bus.div_zero_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(AOP_RTYPE, F_MFLO, 5'd0, 32'h0, 32'h0, st);
      chk("rst_idle", st, 32'd0);
      chk("rst_lo", bus.result_o, 32'h0);
      chk("rst_lo_zero", {31'd0, bus.zero_o}, 32'd1);
      do_op(AOP_RTYPE, F_MFHI, 5'd0, 32'h0, 32'h0, st);
      chk("rst_hi", bus.result_o, 32'h0);
`ifdef ALU_OVF_DETECT_EN
      do_op(AOP_RTYPE, F_ADD, 5'd0, 32'h7FFFFFFF, 32'd1, st);
      chk("ovf_add_result", bus.result_o, 32'h80000000);
      chk("ovf_add_flag", {31'd0, bus.ovf_o}, 32'd1);
      do_op(AOP_RTYPE, F_ADDU, 5'd0, 32'h7FFFFFFF, 32'd1, st);
      chk("ovf_addu_flag", {31'd0, bus.ovf_o}, 32'd0);
      do_op(AOP_SUB, F_ADD, 5'd0, 32'h80000000, 32'd1, st);
      chk("ovf_sub_flag", {31'd0, bus.ovf_o}, 32'd1);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
